// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional signed mode is selected with SEQ_DIV_SIGNED_EN.
package seq_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIV_WIDTH = 4;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int DIV_CNT_W = cnt_w(DIV_WIDTH);

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor P - {0,divisor}: inverted-operand ripple add, carry-in 1.
// Used by seq_div_unit (see SEQ_DIV_SIGNED_EN there).
module div_trial_sub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   p,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   t,
    output logic             borrow
);

    logic [WIDTH:0]   b_inv;
    logic [WIDTH+1:0] c;

    assign b_inv = ~{1'b0, divisor};
    assign c[0]  = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_rip
        assign t[i]   = p[i] ^ b_inv[i] ^ c[i];
        assign c[i+1] = (p[i] & b_inv[i]) | (c[i] & (p[i] ^ b_inv[i]));
    end

    // No carry out of the top bit means the difference went negative
    assign borrow = ~c[WIDTH+1];

endmodule

// File: rtl/seq_div_unit.sv
// Multi-cycle restoring divider, one trial subtraction per clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands.
module seq_div_unit
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_w(WIDTH);

    state_t state, state_n;

    logic [WIDTH:0]   p, p_sh, t, p_nx;
    logic [WIDTH-1:0] q, q_nx, d;
    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
    logic [CW-1:0]    cnt;
    logic             borrow, last, unused_p_msb;

    assign p_sh         = {p[WIDTH-1:0], q[WIDTH-1]};
    assign unused_p_msb = p[WIDTH];

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .p       (p_sh),
        .divisor (d),
        .t       (t),
        .borrow  (borrow)
    );

    assign p_nx = borrow ? p_sh : t;
    assign q_nx = {q[WIDTH-2:0], ~borrow};
    assign last = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q, neg_r;

    // Most-negative magnitude fits as unsigned, so overflow wraps back naturally
    assign a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag = divisor[WIDTH-1] ? -divisor : divisor;
    assign q_fix = neg_q ? -q_nx : q_nx;
    assign r_fix = neg_r ? -p_nx[WIDTH-1:0] : p_nx[WIDTH-1:0];
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_fix = q_nx;
    assign r_fix = p_nx[WIDTH-1:0];
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (start) state_n = (divisor == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (last) state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            p           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            state <= state_n;
            busy  <= (state_n == ST_RUN);
            done  <= (state_n == ST_DONE);
            unique case (state)
                ST_IDLE: begin
                    if (start && divisor == '0) begin
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                    end else if (start) begin
                        p   <= '0;
                        q   <= a_mag;
                        d   <= b_mag;
                        cnt <= '0;
`ifdef SEQ_DIV_SIGNED_EN
                        neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r <= dividend[WIDTH-1];
`endif
                    end
                end
                ST_RUN: begin
                    p   <= p_nx;
                    q   <= q_nx;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: vector table plus corner sequences.
// Honours SEQ_DIV_SIGNED_EN for the expected values.
module tb_seq_div_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    seq_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           acc;
        int           lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    exp_t sb[$];
    vec_t tv[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic exp_t ref_div(input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        exp_t e;
        e.acc = 0;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.z = 1'b1;
            e.lat = 0;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            int sa, sd;
            sa = $signed(a);
            sd = $signed(b);
            e.q = W'(sa / sd);
            e.r = W'(sa % sd);
`else
            e.q = a / b;
            e.r = a % b;
`endif
            e.z = 1'b0;
            e.lat = W;
        end
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest issue
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.z));
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input bit track, output int acc);
        int k;
        k = 0;
        @(negedge clk);
        while ((busy || done) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) check("idle_timeout", 32'(busy), 32'd0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        acc      = cyc + 1;
        e.acc    = acc;
        if (track) sb.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        check("busy_after_accept", 32'(busy), 32'(b != '0));
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        int   acc1, acc2;

`ifdef SEQ_DIV_SIGNED_EN
        tv.push_back('{4'd9,  4'd2,  4'd13, 4'd15, 1'b0});
        tv.push_back('{4'd8,  4'd15, 4'd8,  4'd0,  1'b0});
        tv.push_back('{4'd7,  4'd14, 4'd13, 4'd1,  1'b0});
        tv.push_back('{4'd6,  4'd3,  4'd2,  4'd0,  1'b0});
        tv.push_back('{4'd5,  4'd0,  4'd15, 4'd5,  1'b1});
        tv.push_back('{4'd14, 4'd3,  4'd0,  4'd14, 1'b0});
        tv.push_back('{4'd8,  4'd1,  4'd8,  4'd0,  1'b0});
        tv.push_back('{4'd15, 4'd15, 4'd1,  4'd0,  1'b0});
`else
        tv.push_back('{4'd13, 4'd3,  4'd4,  4'd1,  1'b0});
        tv.push_back('{4'd15, 4'd1,  4'd15, 4'd0,  1'b0});
        tv.push_back('{4'd3,  4'd7,  4'd0,  4'd3,  1'b0});
        tv.push_back('{4'd5,  4'd0,  4'd15, 4'd5,  1'b1});
        tv.push_back('{4'd6,  4'd2,  4'd3,  4'd0,  1'b0});
        tv.push_back('{4'd0,  4'd5,  4'd0,  4'd0,  1'b0});
        tv.push_back('{4'd15, 4'd15, 4'd1,  4'd0,  1'b0});
        tv.push_back('{4'd14, 4'd4,  4'd3,  4'd2,  1'b0});
        tv.push_back('{4'd9,  4'd0,  4'd15, 4'd9,  1'b1});
        tv.push_back('{4'd1,  4'd15, 4'd0,  4'd1,  1'b0});
        tv.push_back('{4'd8,  4'd3,  4'd2,  4'd2,  1'b0});
`endif

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            e.q = tv[i].q;
            e.r = tv[i].r;
            e.z = tv[i].z;
            e.lat = (tv[i].b == '0) ? 0 : W;
            issue(tv[i].a, tv[i].b, e, 1'b1, acc1);
            wait_done();
            @(negedge clk);
            check("hold_quotient", 32'(quotient), 32'(tv[i].q));
            check("hold_dbz", 32'(div_by_zero), 32'(tv[i].z));
        end

        // Back-to-back at minimum issue interval; first result held until accept
        issue(4'd15, 4'd1, ref_div(4'd15, 4'd1), 1'b1, acc1);
        wait_done();
        issue(4'd3, 4'd7, ref_div(4'd3, 4'd7), 1'b1, acc2);
        check("b2b_interval", 32'(acc2 - acc1), 32'(W + 2));
        wait_done();

        // start during RUN with other operands must be ignored
        issue(4'd13, 4'd3, ref_div(4'd13, 4'd3), 1'b1, acc1);
        @(negedge clk);
        dividend = 4'd7;
        divisor  = 4'd2;
        start    = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (W + 4) @(negedge clk);

        // Reset two cycles into RUN abandons the operation silently
        issue(4'd13, 4'd3, ref_div(4'd13, 4'd3), 1'b0, acc1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) @(negedge clk);
        issue(4'd9, 4'd4, ref_div(4'd9, 4'd4), 1'b1, acc1);
        wait_done();

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
